clock_step_ctrl: RTL and testbench
==================================

CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 26, width of divider count and Div input.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles needed to accept a Step_pb level (10 ms at 50 MHz).
REQ-003 SHALL have parameter BURST_WIDTH, default 4, width of Burst_len.
REQ-004 Clock  input  1  single system clock, all logic on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-007 Div  input  DIV_WIDTH  half-period in Clock cycles; 0 treated as 1.
REQ-008 Burst_len  input  BURST_WIDTH  periods per burst; 0 treated as 2^BURST_WIDTH.
REQ-009 Step_pb  input  1  raw asynchronous pushbutton, active-low (pressed = 0).
REQ-010 SlowClk  output  1  registered divided clock, 50% duty, period 2*Div cycles.
REQ-011 Tick  output  1  registered one-Clock-cycle pulse coincident with each SlowClk 0->1 transition.
REQ-012 Busy  output  1  high while a STEP or BURST sequence is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, HIGH, LOW; SlowClk = 1 exactly in HIGH.
REQ-014 Each HIGH and LOW phase SHALL last exactly Div_eff cycles, Div_eff latched on phase entry; Div changes take effect at the next phase boundary.
REQ-015 IDLE->HIGH SHALL occur on the cycle after a start condition; Tick SHALL be 1 in the first HIGH cycle only.
REQ-016 RUN: start condition is Mode==01 in IDLE; LOW->HIGH repeats indefinitely while Mode==01.
REQ-017 STEP: start condition is an accepted press in IDLE; one HIGH+LOW period then IDLE.
REQ-018 BURST: accepted press in IDLE loads a period counter with Burst_len_eff; LOW end decrements it; IDLE when it reaches 0.
REQ-019 Press acceptance: Step_pb SHALL pass a 2-flop synchroniser, then a debouncer updating its level only after DEBOUNCE_CYCLES consecutive equal samples; accepted press = debounced 1->0 edge.
REQ-020 Presses accepted while Busy=1 or in RUN/HALT SHALL be discarded, not queued.
REQ-021 Busy SHALL be 1 from the first HIGH cycle of a STEP/BURST sequence through its final LOW cycle, 0 otherwise.
REQ-022 Any Mode change while not IDLE SHALL abort: next cycle state IDLE, SlowClk=0, Tick=0, Busy=0, counters cleared.
REQ-023 HALT SHALL hold IDLE; no Tick generated.
REQ-024 Phase counter SHALL never exceed Div_eff-1 and SHALL not wrap.

Reset
REQ-025 Reset=0 SHALL immediately force state IDLE, SlowClk=0, Tick=0, Busy=0, all counters 0, synchroniser and debounced level 1 (released).
REQ-026 First start condition SHALL be evaluated on the first rising Clock edge after Reset deasserts; reset mid-sequence SHALL abandon it with no further Tick.

Structure
REQ-027 Package clock_step_pkg SHALL hold mode encodings (MODE_HALT/RUN/STEP/BURST) and FSM state encoding.
REQ-028 Synchroniser+debouncer SHALL be sub-module pb_debounce (parameter DEBOUNCE_CYCLES, outputs level and press pulse), reusable for other board pushbuttons.
REQ-029 clock_step_ctrl SHALL supersede the fixed 1 Hz divider in board top levels; processor clocked by SlowClk or enabled by Tick.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 RUN, Div=3 -> SlowClk period 6 cycles, high 3, Tick every 6th cycle, Busy=0 throughout.
REQ-031 STEP, Div=2, Step_pb low 10 cycles -> exactly one Tick, SlowClk high 2 then low 2, Busy high 4 cycles, then IDLE.
REQ-032 STEP, Step_pb glitch low 3 cycles -> no Tick; second press during Busy -> ignored, single period only.
REQ-033 BURST, Burst_len=3, Div=1 -> 3 Ticks 2 cycles apart, Busy high 6 cycles; Burst_len=0 -> 16 Ticks.
REQ-034 RUN, Div 3->5 mid HIGH phase -> current phase stays 3 cycles, following phases 5; Div=0 -> period 2.
REQ-035 BURST mid-sequence then Mode->HALT or Reset=0 -> SlowClk=0, Busy=0 next cycle/immediately, no further Tick.

Source files
------------

// File: rtl/clock_step_ctrl_pkg.sv
// Shared encodings for the stepping clock controller: operating modes and
// the phase FSM states.
package clock_step_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  // SlowClk is high exactly in ST_HIGH.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/clock_step_ctrl_if.sv
// Control and clock-output bundle of clock_step_ctrl.
// There is no valid/ready handshake on this bus: Mode, Div and Burst_len are
// level controls sampled on every rising Clock edge, Step_pb is a raw
// asynchronous active-low button, and SlowClk/Tick/Busy are registered
// outputs that change only after a rising Clock edge (or on reset).
// dbg_state and dbg_pb_level expose the FSM state and debounced button level.
interface clock_step_ctrl_if #(
  parameter int DIV_WIDTH   = 26,
  parameter int BURST_WIDTH = 4
);
  import clock_step_pkg::*;

  logic [1:0]             Mode;
  logic [DIV_WIDTH-1:0]   Div;
  logic [BURST_WIDTH-1:0] Burst_len;
  logic                   Step_pb;
  logic                   SlowClk;
  logic                   Tick;
  logic                   Busy;
  state_t                 dbg_state;
  logic                   dbg_pb_level;

  modport master (
    output Mode, Div, Burst_len, Step_pb,
    input  SlowClk, Tick, Busy, dbg_state, dbg_pb_level
  );

  modport slave (
    input  Mode, Div, Burst_len, Step_pb,
    output SlowClk, Tick, Busy, dbg_state, dbg_pb_level
  );

endinterface

// File: rtl/clock_step_ctrl_debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a debouncer that
// only changes its level after DEBOUNCE_CYCLES consecutive samples that all
// disagree with the current level. press pulses for one cycle on an accepted
// 1->0 (pressed) edge. Reusable for any active-low board button.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic pb_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchroniser, reset to the released level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], pb_raw};
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q <= '0;
        level <= sync_q[1];
        press <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Divided / single-step / burst clock generator for a slow demo processor.
// A three-state FSM (IDLE, HIGH, LOW) times each phase for Div_eff cycles,
// latching Div_eff on phase entry so Div changes land on phase boundaries.
// RUN free-runs, STEP gives one period per accepted press, BURST gives
// Burst_len_eff periods per press. Changing Mode mid-sequence aborts it.
module clock_step_ctrl
  import clock_step_pkg::*;
#(
  parameter int DIV_WIDTH       = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BURST_WIDTH     = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  clock_step_ctrl_if.slave  bus
);

  state_t                 state, state_nxt;
  logic [DIV_WIDTH-1:0]   phase_cnt, phase_cnt_nxt;
  logic [DIV_WIDTH-1:0]   div_lat, div_lat_nxt;
  logic [BURST_WIDTH:0]   burst_cnt, burst_cnt_nxt;
  logic [1:0]             seq_mode, seq_mode_nxt;
  logic                   slow_q, tick_q, busy_q;
  logic                   slow_nxt, tick_nxt, busy_nxt;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [BURST_WIDTH:0]   burst_eff;
  logic                   press;
  logic                   pb_level;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb (
    .Clock  (Clock),
    .Reset  (Reset),
    .pb_raw (bus.Step_pb),
    .level  (pb_level),
    .press  (press)
  );

  assign div_eff   = (bus.Div == '0) ? DIV_WIDTH'(1) : bus.Div;
  assign burst_eff = (bus.Burst_len == '0) ? {1'b1, {BURST_WIDTH{1'b0}}}
                                           : {1'b0, bus.Burst_len};

  // State, phase counter, latched divisor, period counter and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      div_lat   <= '0;
      burst_cnt <= '0;
      seq_mode  <= MODE_HALT;
      slow_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_cnt_nxt;
      div_lat   <= div_lat_nxt;
      burst_cnt <= burst_cnt_nxt;
      seq_mode  <= seq_mode_nxt;
      slow_q    <= slow_nxt;
      tick_q    <= tick_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Next-state: start conditions, phase timing, period counting and abort.
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    div_lat_nxt   = div_lat;
    burst_cnt_nxt = burst_cnt;
    seq_mode_nxt  = seq_mode;
    unique case (state)
      ST_IDLE: begin
        if (bus.Mode == MODE_RUN) begin
          state_nxt     = ST_HIGH;
          phase_cnt_nxt = '0;
          div_lat_nxt   = div_eff;
          burst_cnt_nxt = '0;
          seq_mode_nxt  = MODE_RUN;
        end else if (press && (bus.Mode == MODE_STEP || bus.Mode == MODE_BURST)) begin
          // Presses in HALT/RUN or while a sequence runs never reach here.
          state_nxt     = ST_HIGH;
          phase_cnt_nxt = '0;
          div_lat_nxt   = div_eff;
          burst_cnt_nxt = (bus.Mode == MODE_STEP) ? (BURST_WIDTH+1)'(1) : burst_eff;
          seq_mode_nxt  = bus.Mode;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (bus.Mode != seq_mode) begin
          state_nxt     = ST_IDLE;
          phase_cnt_nxt = '0;
          div_lat_nxt   = '0;
          burst_cnt_nxt = '0;
          seq_mode_nxt  = MODE_HALT;
        end else if (phase_cnt == div_lat - DIV_WIDTH'(1)) begin
          phase_cnt_nxt = '0;
          div_lat_nxt   = div_eff;
          if (state == ST_HIGH) begin
            state_nxt = ST_LOW;
          end else if (seq_mode == MODE_RUN) begin
            state_nxt = ST_HIGH;
          end else begin
            burst_cnt_nxt = burst_cnt - 1'b1;
            if (burst_cnt <= (BURST_WIDTH+1)'(1)) begin
              state_nxt    = ST_IDLE;
              div_lat_nxt  = '0;
              seq_mode_nxt = MODE_HALT;
            end else begin
              state_nxt = ST_HIGH;
            end
          end
        end else begin
          phase_cnt_nxt = phase_cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        phase_cnt_nxt = '0;
        div_lat_nxt   = '0;
        burst_cnt_nxt = '0;
        seq_mode_nxt  = MODE_HALT;
      end
    endcase
  end

  // Output decode of the next state so every output leaves a flop.
  always_comb begin
    slow_nxt = (state_nxt == ST_HIGH);
    tick_nxt = (state_nxt == ST_HIGH) && (state != ST_HIGH);
    busy_nxt = (state_nxt != ST_IDLE) && (seq_mode_nxt != MODE_RUN);
  end

  assign bus.SlowClk      = slow_q;
  assign bus.Tick         = tick_q;
  assign bus.Busy         = busy_q;
  assign bus.dbg_state    = state;
  assign bus.dbg_pb_level = pb_level;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: a RUN waveform table, directed STEP/BURST/abort
// sequences, then randomized traffic against a queue-based reference model.
module tb_clock_step_ctrl;
  import clock_step_pkg::*;

  localparam int DW = 8;
  localparam int BW = 4;
  localparam int DB = 4;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  clock_step_ctrl_if #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  clock_step_ctrl #(
    .DIV_WIDTH(DW), .DEBOUNCE_CYCLES(DB), .BURST_WIDTH(BW)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- RUN waveform table ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic          s;
    logic          t;
    logic          b;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int n, input logic [1:0] mode, input int div,
                              input logic s, input logic t, input logic b);
    for (int i = 0; i < n; i++) tbl.push_back('{mode, DW'(div), s, t, b});
  endfunction

  // ---------------- watch helpers ----------------
  int w_ticks, w_busy, w_high;
  int tick_at[$];
  bit busy_slow[$];
  bit pb_q[$];

  function automatic void clear_watch();
    w_ticks = 0; w_busy = 0; w_high = 0;
    tick_at.delete(); busy_slow.delete();
  endfunction

  function automatic void load_pb(input int high_n, input int low_n);
    for (int i = 0; i < high_n; i++) pb_q.push_back(1'b1);
    for (int i = 0; i < low_n; i++) pb_q.push_back(1'b0);
  endfunction

  task automatic drive_pb();
    bus.Step_pb = (pb_q.size() > 0) ? pb_q.pop_front() : 1'b1;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (bus.Tick) begin w_ticks++; tick_at.push_back(i); end
      if (bus.Busy) begin w_busy++; busy_slow.push_back(bus.SlowClk); end
      if (bus.SlowClk) w_high++;
      drive_pb();
    end
  endtask

  // Runs until the n-th Tick is seen (bounded); returns 1 if reached.
  task automatic run_to_tick(input int n, output bit found);
    int nt;
    nt = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clock);
      if (bus.Tick) nt++;
      drive_pb();
      if (nt == n) found = 1;
    end
  endtask

  // ---------------- reference model ----------------
  // Expected {SlowClk,Tick,Busy} for upcoming cycles, one phase at a time.
  logic [2:0] exp_q[$];
  bit         m_active, m_last_high, m_level, m_press_pend;
  logic [1:0] m_mode;
  int         m_left;
  bit         raw_h[$];
  logic [2:0] m_cur;

  function automatic void model_reset();
    exp_q.delete();
    m_active = 0; m_last_high = 0; m_level = 1; m_press_pend = 0;
    m_mode = MODE_HALT; m_left = 0; m_cur = 3'b000;
    raw_h.delete();
    for (int i = 0; i < 6; i++) raw_h.push_back(1'b1);
  endfunction

  function automatic void push_phase(input bit high, input int len, input bit busy);
    for (int i = 0; i < len; i++) exp_q.push_back({high, high && (i == 0), busy});
    m_last_high = high;
  endfunction

  // One rising edge: button samples reach the debouncer two edges late, a
  // level change needs four equal samples, and the press pulse is seen by
  // the controller one edge after the change.
  task automatic model_step();
    bit press_now, all_flip;
    int div_eff, bl_eff;
    press_now = m_press_pend;
    m_press_pend = 0;
    raw_h.push_back(bus.Step_pb);
    void'(raw_h.pop_front());
    all_flip = 1;
    for (int i = 0; i < 4; i++) if (raw_h[i] == m_level) all_flip = 0;
    if (all_flip) begin
      m_level = ~m_level;
      m_press_pend = !m_level;
    end
    div_eff = (bus.Div == 0) ? 1 : int'(bus.Div);
    bl_eff  = (bus.Burst_len == 0) ? 16 : int'(bus.Burst_len);
    if (m_active && bus.Mode != m_mode) begin
      m_active = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (bus.Mode == MODE_RUN) begin
        m_active = 1; m_mode = MODE_RUN; m_left = 0;
        push_phase(1, div_eff, 0);
      end else if (press_now && (bus.Mode == MODE_STEP || bus.Mode == MODE_BURST)) begin
        m_active = 1; m_mode = bus.Mode;
        m_left = (bus.Mode == MODE_STEP) ? 1 : bl_eff;
        push_phase(1, div_eff, 1);
      end
    end else if (exp_q.size() == 0) begin
      if (m_last_high) begin
        push_phase(0, div_eff, m_mode != MODE_RUN);
        m_left--;
      end else if (m_mode == MODE_RUN || m_left > 0) begin
        push_phase(1, div_eff, m_mode != MODE_RUN);
      end else begin
        m_active = 0;
      end
    end
    m_cur = m_active ? exp_q.pop_front() : 3'b000;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    int pat;
    bit pb_val;
    int pb_run;

    // Reset state.
    Reset = 1'b0;
    bus.Mode = MODE_HALT; bus.Div = DW'(1); bus.Burst_len = BW'(1); bus.Step_pb = 1'b1;
    repeat (3) @(negedge Clock);
    chk("rst_slow", bus.SlowClk, 0);
    chk("rst_tick", bus.Tick, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_state", bus.dbg_state, ST_IDLE);
    chk("rst_pb_level", bus.dbg_pb_level, 1);
    Reset = 1'b1;

    // HALT holds IDLE.
    clear_watch();
    watch(10);
    chk("halt_ticks", w_ticks, 0);
    chk("halt_state", bus.dbg_state, ST_IDLE);

    // RUN with Div 3, then 5 mid-HIGH, then 0, then HALT.
    add(1, MODE_RUN, 3, 0, 0, 0);
    add(1, MODE_RUN, 3, 1, 1, 0); add(2, MODE_RUN, 3, 1, 0, 0); add(3, MODE_RUN, 3, 0, 0, 0);
    add(1, MODE_RUN, 3, 1, 1, 0); add(2, MODE_RUN, 3, 1, 0, 0); add(3, MODE_RUN, 3, 0, 0, 0);
    add(1, MODE_RUN, 5, 1, 1, 0); add(2, MODE_RUN, 5, 1, 0, 0);
    add(5, MODE_RUN, 5, 0, 0, 0);
    add(1, MODE_RUN, 0, 1, 1, 0); add(4, MODE_RUN, 0, 1, 0, 0);
    add(1, MODE_RUN, 0, 0, 0, 0); add(1, MODE_RUN, 0, 1, 1, 0); add(1, MODE_RUN, 0, 0, 0, 0);
    add(1, MODE_HALT, 0, 1, 1, 0);
    add(2, MODE_HALT, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clock);
      chk($sformatf("run_tbl[%0d].slow", i), bus.SlowClk, tbl[i].s);
      chk($sformatf("run_tbl[%0d].tick", i), bus.Tick, tbl[i].t);
      chk($sformatf("run_tbl[%0d].busy", i), bus.Busy, tbl[i].b);
      bus.Mode = tbl[i].mode;
      bus.Div  = tbl[i].div;
    end

    // STEP, Div 2, button held 10 cycles.
    bus.Mode = MODE_STEP; bus.Div = DW'(2);
    clear_watch(); load_pb(2, 10); watch(40);
    chk("step_ticks", w_ticks, 1);
    chk("step_busy", w_busy, 4);
    chk("step_high", w_high, 2);
    pat = 0;
    foreach (busy_slow[i]) pat = pat * 2 + int'(busy_slow[i]);
    chk("step_shape", pat, 4'b1100);
    chk("step_end_state", bus.dbg_state, ST_IDLE);

    // STEP, 3-cycle glitch is rejected.
    clear_watch(); load_pb(2, 3); watch(20);
    chk("glitch_ticks", w_ticks, 0);
    chk("glitch_busy", w_busy, 0);

    // STEP, Div 8, second press lands while Busy and is dropped.
    bus.Div = DW'(8);
    clear_watch(); load_pb(0, 6); load_pb(6, 8); watch(70);
    chk("step2_ticks", w_ticks, 1);
    chk("step2_busy", w_busy, 16);

    // BURST, 3 periods of Div 1.
    bus.Mode = MODE_BURST; bus.Div = DW'(1); bus.Burst_len = BW'(3);
    clear_watch(); load_pb(1, 8); watch(40);
    chk("burst3_ticks", w_ticks, 3);
    chk("burst3_busy", w_busy, 6);
    if (tick_at.size() >= 3) begin
      chk("burst3_gap0", tick_at[1] - tick_at[0], 2);
      chk("burst3_gap1", tick_at[2] - tick_at[1], 2);
    end

    // BURST, Burst_len 0 means 16 periods.
    bus.Burst_len = BW'(0);
    clear_watch(); load_pb(1, 8); watch(60);
    chk("burst16_ticks", w_ticks, 16);
    chk("burst16_busy", w_busy, 32);

    // BURST aborted by HALT after the second Tick.
    bus.Burst_len = BW'(4); bus.Div = DW'(2);
    load_pb(1, 8);
    run_to_tick(2, found);
    chk("halt_abort_reach", found, 1);
    bus.Mode = MODE_HALT;
    @(negedge Clock);
    chk("halt_abort_slow", bus.SlowClk, 0);
    chk("halt_abort_tick", bus.Tick, 0);
    chk("halt_abort_busy", bus.Busy, 0);
    clear_watch(); watch(20);
    chk("halt_abort_ticks_after", w_ticks, 0);
    pb_q.delete();

    // BURST abandoned by asynchronous reset.
    bus.Mode = MODE_BURST;
    load_pb(1, 8);
    run_to_tick(1, found);
    chk("rst_abort_reach", found, 1);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("rst_abort_slow", bus.SlowClk, 0);
    chk("rst_abort_tick", bus.Tick, 0);
    chk("rst_abort_busy", bus.Busy, 0);
    chk("rst_abort_state", bus.dbg_state, ST_IDLE);
    @(negedge Clock);
    pb_q.delete(); bus.Step_pb = 1'b1;
    Reset = 1'b1;
    clear_watch(); watch(20);
    chk("rst_abort_ticks_after", w_ticks, 0);
    chk("rst_abort_busy_after", w_busy, 0);

    // Randomized traffic against the reference model.
    Reset = 1'b0;
    bus.Mode = MODE_HALT; bus.Step_pb = 1'b1;
    pb_val = 1'b1; pb_run = 0;
    @(negedge Clock);
    model_reset();
    Reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clock);
      model_step();
      @(negedge Clock);
      chk($sformatf("rand@%0d {slow,tick,busy}", c), {bus.SlowClk, bus.Tick, bus.Busy}, m_cur);
      if ($urandom_range(0, 39) == 0) bus.Mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.Div = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) bus.Burst_len = BW'($urandom_range(0, 3));
      if (pb_run == 0) begin
        pb_val = ~pb_val;
        pb_run = $urandom_range(1, 8);
      end
      pb_run--;
      bus.Step_pb = pb_val;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
